// File: rtl/disp_pkg.sv
// disp_pkg: shared constants for the display-sharing arbiter and its decoder.
//   - Requester indices IDX_U..IDX_Y (bit positions in req/gnt).
//   - Mux select codes SEL_U..SEL_Y driven onto {s2,s1,s0}.
//   - Active-low 7-segment patterns {g,f,e,d,c,b,a} for digits 0..7 and blank.
//   - Arbiter state encoding.
package disp_pkg;

  localparam int NUM_REQ = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  localparam logic [2:0] IDX_U = 3'd0;
  localparam logic [2:0] IDX_V = 3'd1;
  localparam logic [2:0] IDX_W = 3'd2;
  localparam logic [2:0] IDX_X = 3'd3;
  localparam logic [2:0] IDX_Y = 3'd4;

  localparam logic [2:0] SEL_U = 3'b000;
  localparam logic [2:0] SEL_V = 3'b001;
  localparam logic [2:0] SEL_W = 3'b010;
  localparam logic [2:0] SEL_X = 3'b011;
  localparam logic [2:0] SEL_Y = 3'b100;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;

  // Segment pattern for a 3-bit digit value.
  function automatic logic [6:0] seg_lookup(input logic [2:0] v);
    logic [6:0] seg;
    case (v)
      3'd0:    seg = SEG_0;
      3'd1:    seg = SEG_1;
      3'd2:    seg = SEG_2;
      3'd3:    seg = SEG_3;
      3'd4:    seg = SEG_4;
      3'd5:    seg = SEG_5;
      3'd6:    seg = SEG_6;
      3'd7:    seg = SEG_7;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Mux select code for a requester index; unknown indices fall back to U.
  function automatic logic [2:0] idx_to_sel(input logic [2:0] idx);
    logic [2:0] s;
    case (idx)
      IDX_U:   s = SEL_U;
      IDX_V:   s = SEL_V;
      IDX_W:   s = SEL_W;
      IDX_X:   s = SEL_X;
      IDX_Y:   s = SEL_Y;
      default: s = SEL_U;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: active-low 7-segment decoder, reusable by any display block.
//   value : DATA_WIDTH-bit digit; only 0..7 have a glyph, anything else blanks.
//   seg   : {g,f,e,d,c,b,a}, low = segment lit.
module seg7_dec
  import disp_pkg::*;
#(
  parameter int DATA_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0] value,
  output logic [6:0]            seg
);

  logic [31:0] wide_s;

  // Widen so out-of-range values of wider sources are detected, then look up.
  always_comb begin
    wide_s = 32'(value);
    if (wide_s < 32'd8) begin
      seg = seg_lookup(wide_s[2:0]);
    end else begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/disp_share_arbiter.sv
// disp_share_arbiter: round-robin owner of the shared select mux and 7-seg digit.
//   Clock, Resetn : rising-edge clock, asynchronous active-low reset.
//   req[4:0]      : requests, bit0=U .. bit4=Y.
//   U..Y          : source values, captured once when the source is granted.
//   hold          : freezes the dwell counter of the active grant.
//   sel           : mux select {s2,s1,s0} of the granted source (kept in IDLE).
//   gnt           : one-hot grant; busy: a grant is active.
//   digit         : captured value; seg7: its active-low glyph, blank when idle.
//   done          : one-cycle pulse after a grant's dwell ends.
// Grants are non-preemptive and last DWELL_CYCLES unheld cycles. At expiry the
// next pending requester is granted on the same edge (no idle gap).
module disp_share_arbiter
  import disp_pkg::*;
#(
  parameter int DATA_WIDTH   = 3,
  parameter int DWELL_CYCLES = 8,
  parameter int CNT_W        = 4
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic [4:0]            req,
  input  logic [DATA_WIDTH-1:0] U,
  input  logic [DATA_WIDTH-1:0] V,
  input  logic [DATA_WIDTH-1:0] W,
  input  logic [DATA_WIDTH-1:0] X,
  input  logic [DATA_WIDTH-1:0] Y,
  input  logic                  hold,
  output logic [2:0]            sel,
  output logic [4:0]            gnt,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] digit,
  output logic [6:0]            seg7,
  output logic                  done
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t                state_r, state_n;
  logic [4:0]            gnt_r, gnt_n;
  logic                  busy_r, busy_n;
  logic [2:0]            sel_r, sel_n;
  logic [DATA_WIDTH-1:0] digit_r, digit_n;
  logic                  done_r, done_n;
  logic [CNT_W-1:0]      cnt_r, cnt_n;
  logic [2:0]            last_r, last_n;
  logic [2:0]            cur_r, cur_n;

  logic [2:0]            pick_base_s;
  logic [3:0]            pick_s;
  logic [DATA_WIDTH-1:0] win_data_s;
  logic [6:0]            dec_s;

  // Scan last+1, last+2, ... (mod 5); returns {found, index}. A base outside
  // 0..4 wraps to U so the index never leaves the request vector.
  function automatic logic [3:0] rr_pick(input logic [4:0] r, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    idx = base;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx >= IDX_Y) ? IDX_U : idx + 3'd1;
      if (res[3] == 1'b0 && r[idx] == 1'b1) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Source value behind a requester index.
  function automatic logic [DATA_WIDTH-1:0] src_mux(
    input logic [2:0]            idx,
    input logic [DATA_WIDTH-1:0] u, v, w, x, y
  );
    logic [DATA_WIDTH-1:0] d;
    case (idx)
      IDX_U:   d = u;
      IDX_V:   d = v;
      IDX_W:   d = w;
      IDX_X:   d = x;
      IDX_Y:   d = y;
      default: d = u;
    endcase
    return d;
  endfunction

  // Next-state and next-output logic for the IDLE/SHOW sequencer.
  always_comb begin
    state_n = state_r;
    gnt_n   = gnt_r;
    busy_n  = busy_r;
    sel_n   = sel_r;
    digit_n = digit_r;
    cnt_n   = cnt_r;
    last_n  = last_r;
    cur_n   = cur_r;
    done_n  = 1'b0;

    // At expiry the current owner becomes "last", so scan from it directly.
    if (state_r == ST_SHOW) begin
      pick_base_s = cur_r;
    end else begin
      pick_base_s = last_r;
    end
    pick_s     = rr_pick(req, pick_base_s);
    win_data_s = src_mux(pick_s[2:0], U, V, W, X, Y);

    case (state_r)
      ST_IDLE: begin
        if (pick_s[3]) begin
          state_n = ST_SHOW;
          cur_n   = pick_s[2:0];
          gnt_n   = 5'b00001 << pick_s[2:0];
          busy_n  = 1'b1;
          sel_n   = idx_to_sel(pick_s[2:0]);
          digit_n = win_data_s;
          cnt_n   = CNT_LOAD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (hold) begin
          cnt_n = cnt_r;
        end else if (cnt_r != CNT_ZERO) begin
          cnt_n = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          done_n = 1'b1;
          last_n = cur_r;
          if (pick_s[3]) begin
            state_n = ST_SHOW;
            cur_n   = pick_s[2:0];
            gnt_n   = 5'b00001 << pick_s[2:0];
            busy_n  = 1'b1;
            sel_n   = idx_to_sel(pick_s[2:0]);
            digit_n = win_data_s;
            cnt_n   = CNT_LOAD;
          end else begin
            state_n = ST_IDLE;
            gnt_n   = 5'b00000;
            busy_n  = 1'b0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = 5'b00000;
        busy_n  = 1'b0;
        cnt_n   = CNT_ZERO;
      end
    endcase
  end

  // State and output registers; reset leaves U as first in line (last = Y).
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= ST_IDLE;
      gnt_r   <= 5'b00000;
      busy_r  <= 1'b0;
      sel_r   <= SEL_U;
      digit_r <= {DATA_WIDTH{1'b0}};
      done_r  <= 1'b0;
      cnt_r   <= CNT_ZERO;
      last_r  <= IDX_Y;
      cur_r   <= IDX_U;
    end else begin
      state_r <= state_n;
      gnt_r   <= gnt_n;
      busy_r  <= busy_n;
      sel_r   <= sel_n;
      digit_r <= digit_n;
      done_r  <= done_n;
      cnt_r   <= cnt_n;
      last_r  <= last_n;
      cur_r   <= cur_n;
    end
  end

  seg7_dec #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_seg7_dec (
    .value(digit_r),
    .seg  (dec_s)
  );

  // seg7 depends only on flops, so it cannot glitch on source changes.
  assign seg7  = busy_r ? dec_s : SEG_BLANK;
  assign gnt   = gnt_r;
  assign busy  = busy_r;
  assign sel   = sel_r;
  assign digit = digit_r;
  assign done  = done_r;

endmodule
